if_id_skid_reg: RTL



---
 rtl/if_id_skid_reg_if.sv | 28 ++
 rtl/if_id_skid_reg.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg_if.sv
// Handshake bundle between fetch, the IF/ID elastic stage and decode.
// The slave modport is the stage itself; the master modport is its environment
// (fetch drives the in_* side, decode drives out_ready).
interface if_id_skid_reg_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [ILEN-1:0] in_inst;
    logic            in_fault;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_inst;
    logic            out_fault;

    modport master (
        output in_valid, in_pc, in_inst, in_fault, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_fault
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_fault, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_fault
    );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID elastic pipeline register with a main entry (drives decode) and a skid
// entry that absorbs the one beat fetch can issue after decode stalls.
// in_ready depends only on registered state, so there is no combinational
// path from out_ready or flush back to fetch.
module if_id_skid_reg #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [ILEN-1:0] NOP_INST = 32'h00000013,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    if_id_skid_reg_if.slave  bus,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Occupancy doubles as state: the main entry is valid in ONE and FULL,
    // the skid entry only in FULL.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [XLEN-1:0] m_pc;
    logic [ILEN-1:0] m_inst;
    logic            m_fault;
    logic [XLEN-1:0] s_pc;
    logic [ILEN-1:0] s_inst;
    logic            s_fault;

    logic m_valid;
    logic s_valid;
    logic in_ready_int;
    logic push;
    logic pop;
    logic load_m_in;
    logic load_m_s;
    logic load_s_in;

    assign m_valid      = (state == ONE) || (state == FULL);
    assign s_valid      = (state == FULL);
    assign in_ready_int = !s_valid;
    assign push         = bus.in_valid && in_ready_int;
    assign pop          = m_valid && bus.out_ready;

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = m_valid;
    assign bus.out_pc    = m_pc;
    assign bus.out_inst  = m_valid ? m_inst : NOP_INST;
    assign bus.out_fault = m_valid && m_fault;
    assign occupancy     = state;

    // Next-state and entry-load decisions; flush overrides push and pop.
    always_comb begin
        state_next = state;
        load_m_in  = 1'b0;
        load_m_s   = 1'b0;
        load_s_in  = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_next = ONE;
                        load_m_in  = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        load_m_in = 1'b1;
                    end else if (push) begin
                        state_next = FULL;
                        load_s_in  = 1'b1;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_next = ONE;
                        load_m_s   = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // State register; reset drops any buffered beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Main entry payload; the PC deliberately keeps its last value when the stage empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_pc    <= '0;
            m_inst  <= NOP_INST;
            m_fault <= 1'b0;
        end else if (load_m_in) begin
            m_pc    <= bus.in_pc;
            m_inst  <= bus.in_inst;
            m_fault <= bus.in_fault;
        end else if (load_m_s) begin
            m_pc    <= s_pc;
            m_inst  <= s_inst;
            m_fault <= s_fault;
        end
    end

    // Skid entry payload; reset only so that no unknown value ever exists in the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_pc    <= '0;
            s_inst  <= NOP_INST;
            s_fault <= 1'b0;
        end else if (load_s_in) begin
            s_pc    <= bus.in_pc;
            s_inst  <= bus.in_inst;
            s_fault <= bus.in_fault;
        end
    end

    // Saturating count of decode-stall cycles; clear beats increment, flush cycles are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (m_valid && !bus.out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
